// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional perf counters are enabled with DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

  typedef enum logic {
    ST_CORE = 1'b0,
    ST_EXT  = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Bits needed to hold 0..max; never less than one.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 2) ? 1 : $clog2(longint'(max) + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with clear and sync active-low reset.
// Clear has priority over increment.
module arb_sat_counter #(
  parameter int unsigned    W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/external arbiter for the single-port data memory.
// Define DMEM_ARB_PERF_EN to enable the stall/ext perf counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_gnt,
  output logic              core_stall,
  input  logic              e_req,
  input  logic              e_we,
  input  logic              e_lock,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic [DATA_W-1:0] e_rdata,
  output logic              e_gnt,
  output logic [ADDR_W-1:0] m_a,
  output logic [DATA_W-1:0] m_wd,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rd,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_ext_cnt
);

  localparam int unsigned WW = cnt_w(MAX_WAIT);
  localparam int unsigned BW = cnt_w(MAX_BURST - 1);
  localparam logic [WW-1:0] L_WMAX = WW'(MAX_WAIT);
  localparam logic [BW-1:0] L_BMAX = BW'(MAX_BURST - 1);

  arb_state_e  r_state;
  arb_state_e  w_nxt;
  logic [WW-1:0] w_wait;
  logic [BW-1:0] w_burst;
  logic        w_to_ext;
  logic        w_stay;
  logic        w_wait_inc;
  logic        w_wait_clr;
  logic        w_burst_inc;
  logic        w_burst_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_CORE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_to_ext    = 1'b0;
    w_stay      = 1'b0;
    w_wait_inc  = 1'b0;
    w_wait_clr  = 1'b1;
    w_burst_inc = 1'b0;
    w_burst_clr = 1'b1;
    unique case (r_state)
      ST_CORE: begin
        w_to_ext   = e_req && (!c_req || (w_wait == L_WMAX));
        w_wait_inc = e_req && c_req;
        w_wait_clr = !e_req || w_to_ext;
        w_nxt      = w_to_ext ? ST_EXT : ST_CORE;
      end
      ST_EXT: begin
        // Burst limit only bites while the core is waiting.
        w_stay      = e_req && e_lock && !(c_req && (w_burst == L_BMAX));
        w_burst_inc = w_stay;
        w_burst_clr = !w_stay;
        w_nxt       = w_stay ? ST_EXT : ST_CORE;
      end
      default: ;
    endcase
  end

  always_comb begin
    c_gnt      = 1'b0;
    e_gnt      = 1'b0;
    core_stall = 1'b0;
    m_we       = 1'b0;
    m_a        = '0;
    m_wd       = '0;
    if (rst_n) begin
      if (r_state == ST_EXT) begin
        e_gnt      = e_req;
        core_stall = c_req;
        m_we       = e_req && e_we;
        m_a        = e_addr;
        m_wd       = e_wdata;
      end else begin
        c_gnt = c_req;
        m_we  = c_req && c_we;
        m_a   = c_addr;
        m_wd  = c_wdata;
      end
    end
  end

  assign c_rdata = m_rd;
  assign e_rdata = m_rd;

  arb_sat_counter #(.W(WW), .MAX(L_WMAX)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wait_inc),
    .i_clr (w_wait_clr),
    .o_cnt (w_wait)
  );

  arb_sat_counter #(.W(BW), .MAX(L_BMAX)) u_burst (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_burst_inc),
    .i_clr (w_burst_clr),
    .o_cnt (w_burst)
  );

`ifdef DMEM_ARB_PERF_EN
  arb_sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (core_stall),
    .i_clr (1'b0),
    .o_cnt (perf_stall_cnt)
  );

  arb_sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_perf_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (e_gnt),
    .i_clr (1'b0),
    .o_cnt (perf_ext_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_ext_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus
// hand-written burst / reset sequences, expectations via a queue.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_gnt, core_stall;
  logic        e_req, e_we, e_lock;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_gnt;
  logic [31:0] m_a, m_wd, m_rd;
  logic        m_we;
  logic [31:0] perf_stall_cnt, perf_ext_cnt;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_gnt(c_gnt), .core_stall(core_stall),
    .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr),
    .e_wdata(e_wdata), .e_rdata(e_rdata), .e_gnt(e_gnt),
    .m_a(m_a), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd),
    .perf_stall_cnt(perf_stall_cnt), .perf_ext_cnt(perf_ext_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // own: 0 = core owns memory, 1 = external owns, 2 = in reset
  typedef struct {
    bit          rst;
    bit          cr, cw, er, ew, el;
    logic [31:0] ca, cd, ea, ed, rd;
    int          own;
  } vec_t;

  typedef struct {
    bit          cg, eg, st, we;
    logic [31:0] ma, wd, crd, erd;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_stall = 0;
  int   t_ext   = 0;

  function automatic vec_t mk(bit rst, bit cr, bit cw, bit er, bit ew,
                              bit el, logic [31:0] ca, logic [31:0] cd,
                              logic [31:0] ea, logic [31:0] ed,
                              logic [31:0] rd, int own);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw;
    v.er = er; v.ew = ew; v.el = el;
    v.ca = ca; v.cd = cd; v.ea = ea; v.ed = ed; v.rd = rd;
    v.own = own;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic run(vec_t v);
    exp_t e;
    exp_t g;
    rst_n   = v.rst;
    c_req   = v.cr;  c_we = v.cw;
    c_addr  = v.ca;  c_wdata = v.cd;
    e_req   = v.er;  e_we = v.ew; e_lock = v.el;
    e_addr  = v.ea;  e_wdata = v.ed;
    m_rd    = v.rd;
    e = '{cg: 0, eg: 0, st: 0, we: 0,
          ma: 32'h0, wd: 32'h0, crd: v.rd, erd: v.rd};
    if (v.own == 0) begin
      e.cg = v.cr; e.we = v.cr & v.cw;
      e.ma = v.ca; e.wd = v.cd;
    end else if (v.own == 1) begin
      e.eg = v.er; e.st = v.cr; e.we = v.er & v.ew;
      e.ma = v.ea; e.wd = v.ed;
    end
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk("c_gnt",      32'(c_gnt),      32'(g.cg));
    chk("e_gnt",      32'(e_gnt),      32'(g.eg));
    chk("core_stall", 32'(core_stall), 32'(g.st));
    chk("m_we",       32'(m_we),       32'(g.we));
    chk("m_a",        m_a,             g.ma);
    chk("m_wd",       m_wd,            g.wd);
    chk("c_rdata",    c_rdata,         g.crd);
    chk("e_rdata",    e_rdata,         g.erd);
    if (!v.rst) begin
      t_stall = 0;
      t_ext   = 0;
    end else begin
      t_stall += int'(g.st);
      t_ext   += int'(g.eg);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  localparam logic [31:0] CA = 32'h0000_0200;
  localparam logic [31:0] EA = 32'h0000_0300;
  localparam logic [31:0] ED = 32'h0000_00A5;
  localparam logic [31:0] RD = 32'hC0DE_0001;

  initial begin
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    e_req = 0; e_we = 0; e_lock = 0; e_addr = 0; e_wdata = 0;
    m_rd  = 0;

    // reset, release, external write with idle core
    tbl.push_back(mk(0,1,1,1,1,0,32'h100,32'h11,32'h40,32'hDEADBEEF,RD,2));
    tbl.push_back(mk(1,1,0,0,0,0,32'h100,32'h11,32'h40,32'hDEADBEEF,RD,0));
    tbl.push_back(mk(1,0,0,1,1,0,32'h100,32'h11,32'h40,32'hDEADBEEF,RD,0));
    tbl.push_back(mk(1,0,0,1,1,0,32'h100,32'h11,32'h40,32'hDEADBEEF,RD,1));
    tbl.push_back(mk(1,1,1,0,0,0,32'h104,32'h55,32'h40,32'hDEADBEEF,RD,0));
    // external read
    tbl.push_back(mk(1,0,0,1,0,0,32'h104,32'h55,32'h10,32'h0,32'h1234,0));
    tbl.push_back(mk(1,0,0,1,0,0,32'h104,32'h55,32'h10,32'h0,32'h1234,1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h104,32'h55,32'h10,32'h0,RD,0));
    // starvation: five core grants then preemption
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,0));
    tbl.push_back(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,1));
    tbl.push_back(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));
    // wait counter clears when e_req drops
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,0));
    tbl.push_back(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,0));
    tbl.push_back(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,1));
    tbl.push_back(mk(1,0,0,0,0,0,CA,0,EA,ED,RD,0));
    // e_req drops while external owns the memory
    tbl.push_back(mk(1,0,0,1,0,1,CA,0,EA,ED,RD,0));
    tbl.push_back(mk(1,0,0,0,0,0,CA,0,EA,ED,RD,1));
    tbl.push_back(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // contended locked burst: 5 core, 8 ext, 5 core, 2 ext
    for (int i = 0; i < 5; i++) run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,0));
    for (int i = 0; i < 8; i++) run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,1));
    for (int i = 0; i < 5; i++) run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,0));
    run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,1));
    run(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,1));
    run(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));

    // uncontended burst saturates, limit applies once core asks
    run(mk(1,0,0,1,1,1,CA,0,EA,ED,RD,0));
    for (int i = 0; i < 12; i++) run(mk(1,0,0,1,1,1,CA,0,EA,ED,RD,1));
    run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,1));
    run(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));

    // reset mid-burst
    run(mk(1,0,0,1,1,1,CA,0,EA,ED,RD,0));
    for (int i = 0; i < 3; i++) run(mk(1,0,0,1,1,1,CA,0,EA,ED,RD,1));
    run(mk(0,1,1,1,1,1,CA,0,EA,ED,RD,2));
    for (int i = 0; i < 5; i++) run(mk(1,1,0,1,1,1,CA,0,EA,ED,RD,0));
    run(mk(1,1,0,1,1,0,CA,0,EA,ED,RD,1));
    run(mk(1,1,0,0,0,0,CA,0,EA,ED,RD,0));

`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'(t_stall));
    chk("perf_ext_cnt",   perf_ext_cnt,   32'(t_ext));
`else
    chk("perf_stall_cnt", perf_stall_cnt, 32'h0);
    chk("perf_ext_cnt",   perf_ext_cnt,   32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
